// File: rtl/m_rst_seq.sv
// Reset sequencer for active-low async set/reset flop domains.
// A global async reset is synchronised on release. The domains are then
// released one at a time in index order, each after its own programmable delay.
// Software can request a full re-reset. That request holds every domain low
// for HOLD_CYC cycles and acknowledges with a one-cycle pulse.

// One domain's reset flop. It is cleared by the async reset or by a
// software re-reset, and set when the sequencer reaches this domain.
module m_rst_seq_dom (
  input  logic CK,
  input  logic RST,
  input  logic clr_i,
  input  logic rel_i,
  output logic dom_rst_n_o
);

  logic rst_n_q;

  // Clearing wins over release; the sequencer never asserts both at once.
  always_ff @(posedge CK or posedge RST) begin
    if (RST)        rst_n_q <= 1'b0;
    else if (clr_i) rst_n_q <= 1'b0;
    else if (rel_i) rst_n_q <= 1'b1;
  end

  assign dom_rst_n_o = rst_n_q;

endmodule

module m_rst_seq #(
  parameter int N_DOM       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DLY_W       = 8,
  parameter int HOLD_CYC    = 4
) (
  input  logic                   CK,
  input  logic                   RST,
  input  logic [N_DOM*DLY_W-1:0] DLY,
  input  logic                   SW_RST_REQ,
  output logic                   SW_RST_ACK,
  output logic [N_DOM-1:0]       DOM_RST_N,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  // The delay table is padded to a power of two so that idx+1 can index it
  // without a range check. Padding entries are never loaded.
  localparam int N_PAD = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(N_DOM - 1);
  localparam logic [DLY_W-1:0] HOLD_L = DLY_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_IDLE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_nx;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               ack_q, ack_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               rst_s;
  logic [N_DOM-1:0]   rel;
  logic               clr;
  logic [DLY_W-1:0]   dly_a [N_PAD];

  // Unpack the flat delay bus into per-domain fields.
  for (genvar i = 0; i < N_PAD; i++) begin : g_dly
    if (i < N_DOM) begin : g_fld
      assign dly_a[i] = DLY[i*DLY_W +: DLY_W];
    end else begin : g_pad
      assign dly_a[i] = '0;
    end
  end

  // Release synchroniser: asserts at once, deasserts SYNC_STAGES edges after RST falls.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  assign rst_s  = sync_q[SYNC_STAGES-1];
  assign idx_nx = idx_q + IDX_W'(1);

  // Sequencer state, domain index, delay counter and registered status flags.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= S_SYNC;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state logic. It also produces the per-domain release strobes and the global clear.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ack_d   = 1'b0;
    rel     = '0;
    clr     = 1'b0;
    case (state_q)
      S_SYNC: begin
        if (!rst_s) begin
          state_d = S_WAIT;
          idx_d   = '0;
          cnt_d   = dly_a[0];
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DLY_W'(1);
        end else begin
          for (int i = 0; i < N_DOM; i++)
            if (idx_q == IDX_W'(i)) rel[i] = 1'b1;
          if (idx_q == LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            // The next field is sampled here only. Later DLY changes wait for the next run.
            idx_d = idx_nx;
            cnt_d = dly_a[idx_nx];
          end
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DLY_W'(1);
        end else begin
          ack_d   = 1'b1;
          state_d = S_WAIT;
          idx_d   = '0;
          cnt_d   = dly_a[0];
        end
      end
      S_IDLE: begin
        if (SW_RST_REQ) begin
          clr     = 1'b1;
          done_d  = 1'b0;
          state_d = S_HOLD;
          cnt_d   = HOLD_L;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    m_rst_seq_dom u_dom (
      .CK          (CK),
      .RST         (RST),
      .clr_i       (clr),
      .rel_i       (rel[i]),
      .dom_rst_n_o (DOM_RST_N[i])
    );
  end

  assign SW_RST_ACK = ack_q;
  assign DONE       = done_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_m_rst_seq.sv
// Self-checking bench for m_rst_seq.
// Expected output transitions are derived from release-edge arithmetic and queued per run.
// A negedge monitor pops one entry each time any output changes.
module tb_m_rst_seq;
  localparam int N  = 4;
  localparam int SS = 2;
  localparam int DW = 8;
  localparam int HC = 4;

  logic          CK = 1'b0;
  logic          RST = 1'b0;
  logic [N*DW-1:0] DLY = '0;
  logic          SW_RST_REQ = 1'b0;
  logic          SW_RST_ACK;
  logic [N-1:0]  DOM_RST_N;
  logic          BUSY;
  logic          DONE;

  typedef struct packed {
    logic [N-1:0] dom;
    logic         done;
    logic         ack;
    logic         busy;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } ev_t;

  ev_t  q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  obs_t last = '{dom: '0, done: 1'b0, ack: 1'b0, busy: 1'b1};

  m_rst_seq #(.N_DOM(N), .SYNC_STAGES(SS), .DLY_W(DW), .HOLD_CYC(HC)) dut (
    .CK         (CK),
    .RST        (RST),
    .DLY        (DLY),
    .SW_RST_REQ (SW_RST_REQ),
    .SW_RST_ACK (SW_RST_ACK),
    .DOM_RST_N  (DOM_RST_N),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  // Any change in the outputs must match the next queued expectation, in both edge and value.
  always @(negedge CK) begin : mon
    obs_t cur;
    ev_t  e;
    cur = '{dom: DOM_RST_N, done: DONE, ack: SW_RST_ACK, busy: BUSY};
    if (cur !== last) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: edge %0d got %b want no change", cyc, cur);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.o !== cur) begin
          errors++;
          $display("FAIL event: edge %0d got %b want edge %0d value %b", cyc, cur, e.cyc, e.o);
        end
      end
      last = cur;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #2;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  function automatic logic [N*DW-1:0] pack(input int d[N]);
    logic [N*DW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*DW +: DW] = DW'(d[i]);
    return p;
  endfunction

  // Model of one run starting at edge t0.
  // For a software request, t0 is the accept edge. For power-on, t0 is the last
  // edge before RST falls. Domain i releases at a cumulative edge offset from WAIT
  // entry. The model pushes every edge where the expected outputs change.
  task automatic expect_run(input int t0, input bit sw, input int d[N], output int rlast);
    int   r[N];
    int   acc;
    obs_t prev, cur;
    acc = sw ? HC : SS + 1;
    for (int i = 0; i < N; i++) begin
      acc  += d[i] + 1;
      r[i] = acc;
    end
    rlast = r[N-1];
    prev = sw ? '{dom: '1, done: 1'b1, ack: 1'b0, busy: 1'b0}
              : '{dom: '0, done: 1'b0, ack: 1'b0, busy: 1'b1};
    for (int k = 0; k <= rlast + 2; k++) begin
      for (int i = 0; i < N; i++) cur.dom[i] = (k >= r[i]);
      cur.done = (k >= rlast);
      cur.busy = !cur.done;
      cur.ack  = sw && (k == HC);
      if (cur !== prev) q.push_back('{cyc: t0 + k, o: cur});
      prev = cur;
    end
  endtask

  task automatic sw_req(input int d[N], output int t0);
    int rl;
    SW_RST_REQ = 1'b1;
    t0 = cyc + 1;
    expect_run(t0, 1'b1, d, rl);
    step();
    SW_RST_REQ = 1'b0;
  endtask

  task automatic power_on(input int d[N]);
    int rl;
    DLY = pack(d);
    step();
    expect_run(cyc, 1'b0, d, rl);
    RST = 1'b0;
  endtask

  // Asynchronous abort: the outputs must reach reset values before any clock edge.
  task automatic abort_rst();
    q.delete();
    q.push_back('{cyc: cyc, o: '{dom: '0, done: 1'b0, ack: 1'b0, busy: 1'b1}});
    RST = 1'b1;
    #1;
    chk("async_dom", int'(DOM_RST_N), 0);
    chk("async_done", int'(DONE), 0);
    chk("async_busy", int'(BUSY), 1);
    chk("async_ack", int'(SW_RST_ACK), 0);
  endtask

  task automatic drain(input string nm);
    for (int n = 0; n < 2000 && q.size() != 0; n++) step();
    chk(nm, q.size(), 0);
    repeat (3) step();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int d[N];
    int dz[N];
    int t0, t1, rl, l2, nv;
    d  = '{3, 0, 5, 1};
    dz = '{0, 0, 0, 0};

    #1 RST = 1'b1;
    #2;
    chk("rst_dom", int'(DOM_RST_N), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_busy", int'(BUSY), 1);
    chk("rst_ack", int'(SW_RST_ACK), 0);
    step();

    // Power-on with DLY fields 3,0,5,1: the domains release at edges 7, 8, 14 and 16.
    power_on(d);
    drain("poweron_drain");

    // Software re-reset. Requests pulsed in HOLD and in WAIT must be ignored.
    DLY = pack(d);
    sw_req(d, t0);
    step();
    SW_RST_REQ = 1'b1;
    step();
    SW_RST_REQ = 1'b0;
    wait_cyc(t0 + 4);
    SW_RST_REQ = 1'b1;
    step();
    SW_RST_REQ = 1'b0;
    drain("swrst_drain");

    // Abort mid-WAIT after domain 1 has released, then restart with all-zero delays.
    sw_req(d, t0);
    wait_cyc(t0 + HC + (d[0] + 1) + (d[1] + 1) + 1);
    abort_rst();
    step();
    step();
    power_on(dz);
    drain("zero_dly_drain");

    // Change field 2 while domain 2 counts. The old value applies now, the new one on the next run.
    d = '{$urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(2, 6), $urandom_range(0, 4)};
    DLY = pack(d);
    sw_req(d, t0);
    l2 = t0 + HC + (d[0] + 1) + (d[1] + 1);
    wait_cyc(l2);
    nv = d[2] + 1 + $urandom_range(0, 3);
    DLY[2*DW +: DW] = DW'(nv);
    drain("dly_change_drain");
    d[2] = nv;
    sw_req(d, t0);
    drain("dly_new_drain");

    // A request held high across IDLE re-entry is accepted on the first IDLE edge.
    for (int i = 0; i < N; i++) d[i] = $urandom_range(0, 5);
    DLY = pack(d);
    SW_RST_REQ = 1'b1;
    t0 = cyc + 1;
    expect_run(t0, 1'b1, d, rl);
    t1 = t0 + rl + 1;
    expect_run(t1, 1'b1, d, rl);
    wait_cyc(t1);
    SW_RST_REQ = 1'b0;
    drain("held_req_drain");

    // Random mix of software re-resets and full power-on sequences.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < N; i++) d[i] = $urandom_range(0, 9);
      DLY = pack(d);
      if ($urandom_range(0, 1) == 1) begin
        sw_req(d, t0);
      end else begin
        abort_rst();
        step();
        power_on(d);
      end
      drain("random_drain");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_rst_seq.md
Name: m_rst_seq

Overview:
- Reset sequencer for the std-cell flop domains that use active-low async set/reset pins (SN/RN).
- Synchronises release of a global async reset, then releases N_DOM downstream reset domains one at a time. Each domain waits a programmable per-domain delay before release.
- Supports a software-requested full re-reset with a fixed hold time and a completion acknowledge.
- Sits at the top of each subsystem, between the pad/system reset and the SN/RN nets of the domain flops.

Parameters:
N_DOM, 4, number of reset domains released in index order 0..N_DOM-1 (>=1)
SYNC_STAGES, 2, depth of the RST release synchroniser (>=2)
DLY_W, 8, width of each per-domain delay field
HOLD_CYC, 4, cycles all domains are held in reset on a software request (>=1, <2^DLY_W)

Ports:
CK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
DLY  input  N_DOM*DLY_W  per-domain release delay; field i = DLY[i*DLY_W +: DLY_W]
SW_RST_REQ  input  1  software re-reset request, level-sampled
SW_RST_ACK  output  1  one-cycle pulse when the software hold phase ends
DOM_RST_N  output  N_DOM  per-domain reset, active-low, drives downstream SN/RN
BUSY  output  1  sequence in progress (not IDLE)
DONE  output  1  all domains released

Behaviour:
- Clock and reset: one clock CK. Reset RST is asynchronous and active-high.
- RST=1 (asynchronous):
  - DOM_RST_N=0, DONE=0, SW_RST_ACK=0, BUSY=1.
  - Synchroniser chain set to all-ones; state=SYNC; idx=0; cnt=0.
  - Assertion is immediate with no clock needed. Only deassertion is synchronised.
- Synchroniser: SYNC_STAGES flops with async set, shifting 0 in. rst_s = last stage. rst_s falls on the SYNC_STAGES-th CK edge after RST falls.
- States: SYNC, WAIT, HOLD, IDLE.
- SYNC: at the first edge with rst_s=0 -> WAIT, idx=0, cnt=DLY field 0.
- WAIT:
  - cnt!=0: cnt decrements.
  - cnt==0 at an edge: DOM_RST_N[idx] goes 1.
    - If idx==N_DOM-1: -> IDLE, DONE=1 on the same edge.
    - Otherwise: idx increments and cnt loads DLY field idx+1.
  - Net effect: domain i releases DLY[i]+1 edges after its count loads. DLY=0 gives a 1-cycle spacing.
- DLY is sampled only at a load. Changes mid-count do not affect the current domain.
- Released domains stay released until RST or a software request.
- IDLE: BUSY=0, DONE=1. On an edge with SW_RST_REQ=1:
  - All DOM_RST_N go 0 and DONE goes 0.
  - State -> HOLD, cnt=HOLD_CYC-1.
- HOLD:
  - cnt decrements.
  - At the edge where cnt==0: SW_RST_ACK=1 for exactly one cycle, -> WAIT, idx=0, cnt=DLY field 0.
  - Domains are therefore held low HOLD_CYC cycles before the delay sequence restarts.
- SW_RST_REQ is ignored outside IDLE. A request held high across IDLE re-entry triggers a new sequence on the first IDLE edge.
- RST asserted in any state, including mid-HOLD or mid-WAIT, aborts immediately to the reset values. RST has priority over every other event.
- All outputs are registered, with no combinational path from inputs to outputs.
- BUSY = (state != IDLE).
- DOM_RST_N and SW_RST_ACK are glitch-free flop outputs.

Test Plan:
- Power-on sequence (N_DOM=4, SYNC_STAGES=2, DLY={3,0,5,1}), RST falls before edge 1:
  - rst_s falls at edge 2; WAIT entered at edge 3.
  - DOM_RST_N bits rise at edges 7, 8, 14 and 16.
  - DONE=1 and BUSY=0 at edge 16.
- All-zero DLY: domains release on 4 consecutive edges starting edge 4. DONE is asserted with the last release.
- Software reset (HOLD_CYC=4) from IDLE, SW_RST_REQ=1 one cycle:
  - Next edge: DOM_RST_N=0000, DONE=0.
  - SW_RST_ACK pulses exactly 1 cycle, 4 edges later.
  - The release pattern then matches the power-on scenario offsets measured from WAIT entry.
- SW_RST_REQ pulsed during WAIT and during HOLD: no effect on timing. Exactly one SW_RST_ACK per accepted request.
- RST asserted asynchronously mid-WAIT (after domain 1 released):
  - All DOM_RST_N=0 without a clock edge.
  - After release, the full sequence restarts from domain 0 with the SYNC latency.
- DLY field 2 changed while domain 2 is counting: release still uses the value loaded at its load edge. The new value applies on the next sequence.
